// File: rtl/vout_dpi.sv
// vout_dpi: DPI raster generator that serialises 4-pixel Y8 words into grey 24-bit RGB pixels.
module vout_dpi #(
    parameter int         H_ACTIVE = 800,
    parameter int         H_FP     = 40,
    parameter int         H_SYNC   = 48,
    parameter int         H_BP     = 40,
    parameter int         V_ACTIVE = 600,
    parameter int         V_FP     = 1,
    parameter int         V_SYNC   = 3,
    parameter int         V_BP     = 21,
    parameter logic       HS_POL   = 1'b0,
    parameter logic       VS_POL   = 1'b0,
    parameter logic [7:0] FILL     = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [31:0] s_pixel,
    input  logic        s_valid,
    output logic        s_ready,
    output logic        frame_start,
    output logic        underrun,
    output logic        dpi_vsync,
    output logic        dpi_hsync,
    output logic        dpi_de,
    output logic [23:0] dpi_pixel
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam logic [HW-1:0] H_LAST = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT  = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_BEG = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT  = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic          running_q, running_d;
    logic [HW-1:0] h_q, h_d;
    logic [VW-1:0] v_q, v_d;
    logic [1:0]    lane_q, lane_d;
    logic [31:0]   word_q, word_d;
    logic          fill_q, fill_d;
    logic          de_q, de_d, hs_q, hs_d, vs_q, vs_d, fs_q, fs_d, ur_q, ur_d;
    logic [23:0]   pix_q, pix_d;
    logic          active_c, h_end, v_end;
    logic [7:0]    y_c;

    always_comb begin
        h_end     = h_q == H_LAST;
        v_end     = v_q == V_LAST;
        active_c  = running_q && h_q < H_ACT && v_q < V_ACT;
        s_ready   = active_c && lane_q == 2'd0;
        // en only matters when idle or on the last clock of a frame
        running_d = running_q ? (!(h_end && v_end) || en) : en;
        h_d       = (!running_q || h_end) ? '0 : h_q + 1'b1;
        v_d       = !running_q ? '0 : h_end ? (v_end ? '0 : v_q + 1'b1) : v_q;
        lane_d    = active_c ? lane_q + 2'd1 : 2'd0;
        word_d    = (s_ready && s_valid) ? s_pixel : word_q;
        fill_d    = s_ready ? !s_valid : fill_q;
        y_c       = s_ready ? (s_valid ? s_pixel[7:0] : FILL)
                            : (fill_q ? FILL : word_q[{lane_q, 3'b000} +: 8]);
        de_d      = active_c;
        pix_d     = active_c ? {3{y_c}} : '0;
        hs_d      = (running_q && h_q >= HS_BEG && h_q < HS_END) ? HS_POL : ~HS_POL;
        vs_d      = (running_q && v_q >= VS_BEG && v_q < VS_END) ? VS_POL : ~VS_POL;
        fs_d      = running_q && h_q == '0 && v_q == VS_BEG;
        ur_d      = ur_q || (s_ready && !s_valid);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            running_q <= 1'b0;
            h_q       <= '0;
            v_q       <= '0;
            lane_q    <= '0;
            word_q    <= '0;
            fill_q    <= 1'b0;
            de_q      <= 1'b0;
            hs_q      <= ~HS_POL;
            vs_q      <= ~VS_POL;
            pix_q     <= '0;
            fs_q      <= 1'b0;
            ur_q      <= 1'b0;
        end else begin
            running_q <= running_d;
            h_q       <= h_d;
            v_q       <= v_d;
            lane_q    <= lane_d;
            word_q    <= word_d;
            fill_q    <= fill_d;
            de_q      <= de_d;
            hs_q      <= hs_d;
            vs_q      <= vs_d;
            pix_q     <= pix_d;
            fs_q      <= fs_d;
            ur_q      <= ur_d;
        end
    end

    assign dpi_de      = de_q;
    assign dpi_hsync   = hs_q;
    assign dpi_vsync   = vs_q;
    assign dpi_pixel   = pix_q;
    assign frame_start = fs_q;
    assign underrun    = ur_q;
endmodule
